// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the serial program loader.
package prog_loader_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;
  localparam int         UART_BITS   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_VERIFY,
    S_CHECK,
    S_RUN,
    S_ERROR
  } load_state_t;

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, down-counting bit timer, LSB-first shifter.
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half-bit wait, start bit re-checked
// RX_DATA  | sampling data bits at bit centres
// RX_STOP  | sampling stop bit
// RX_BREAK | framing error seen, waiting for line to go high again
module prog_loader_uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] rx_byte,
  output logic       valid,
  output logic       ferr
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t     state, state_nxt;
  logic          rx_meta, rx_sync;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tc;

  assign tc      = (timer == '0);
  assign rx_byte = shreg;
  assign valid   = (state == RX_STOP) && tc && rx_sync;
  assign ferr    = (state == RX_STOP) && tc && !rx_sync;

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (!rx_sync) state_nxt = RX_START;
      RX_START: if (tc) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tc && bit_cnt == 3'(UART_BITS - 1)) state_nxt = RX_STOP;
      RX_STOP:  if (tc) state_nxt = rx_sync ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_sync) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state   <= RX_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= RXD;
      rx_sync <= rx_meta;
      state   <= state_nxt;
      // Idle keeps the half-bit preload so the start re-check lands mid-bit.
      if (state == RX_IDLE)  timer <= TW'(CLKS_PER_BIT / 2 - 1);
      else if (tc)           timer <= TW'(CLKS_PER_BIT - 1);
      else                   timer <= timer - 1'b1;
      if (state == RX_START) bit_cnt <= '0;
      else if (state == RX_DATA && tc) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {rx_sync, shreg[7:1]};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image over UART, writes memory, releases the CPU.
// Optional readback check after each write is enabled by defining PROG_LOADER_VERIFY_EN.
// state    | meaning
// S_IDLE   | wait for header byte, other bytes dropped
// S_COUNT  | receive word count
// S_DATA   | assemble 4 bytes into a word
// S_WRITE  | one-cycle memory write
// S_VERIFY | one-cycle readback compare (verify build only)
// S_CHECK  | wait for checksum byte
// S_RUN    | load done, CPU released
// S_ERROR  | load failed, CPU held; header restarts the load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_WORDS    = 128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RXD,
  output logic        CPU_RST,
  output logic        CS,
  output logic        WE,
  output logic [6:0]  ADDR,
  output logic        BUS_OE,
  output logic [31:0] BUS_DATA,
  input  logic [31:0] MEM_DIN,
  output logic        DONE,
  output logic        ERR
);

  load_state_t state, state_nxt;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;
  logic [6:0]  addr_q, last_addr;
  logic [1:0]  byte_cnt;
  logic [31:0] word_q;
  logic [7:0]  chk_q;
  logic        last_word, count_ok, header_seen, word_done;

  prog_loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK     (CLK),
    .RST     (RST),
    .RXD     (RXD),
    .rx_byte (rx_byte),
    .valid   (rx_valid),
    .ferr    (rx_ferr)
  );

  assign last_word   = (addr_q == last_addr);
  assign header_seen = rx_valid && (rx_byte == HEADER_BYTE);
  // A count byte of zero stands for a full 128-word image.
  assign count_ok    = (rx_byte == 8'd0) ? (MEM_WORDS >= 128)
                                         : ({24'd0, rx_byte} <= 32'(MEM_WORDS));

`ifdef PROG_LOADER_VERIFY_EN
  assign word_done = (state == S_VERIFY) && (MEM_DIN == word_q);
`else
  assign word_done = (state == S_WRITE);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (header_seen) state_nxt = S_COUNT;
      S_COUNT:  if (rx_ferr) state_nxt = S_ERROR;
                else if (rx_valid) state_nxt = count_ok ? S_DATA : S_ERROR;
      S_DATA:   if (rx_ferr) state_nxt = S_ERROR;
                else if (rx_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
`ifdef PROG_LOADER_VERIFY_EN
      S_WRITE:  state_nxt = S_VERIFY;
`else
      S_WRITE:  state_nxt = last_word ? S_CHECK : S_DATA;
`endif
      S_VERIFY: if (MEM_DIN != word_q) state_nxt = S_ERROR;
                else state_nxt = last_word ? S_CHECK : S_DATA;
      S_CHECK:  if (rx_ferr) state_nxt = S_ERROR;
                else if (rx_valid) state_nxt = (rx_byte == chk_q) ? S_RUN : S_ERROR;
      S_RUN:    state_nxt = S_RUN;
      S_ERROR:  if (header_seen) state_nxt = S_COUNT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q    <= '0;
      last_addr <= '0;
      byte_cnt  <= '0;
      word_q    <= '0;
      chk_q     <= '0;
    end else begin
      if ((state == S_IDLE || state == S_ERROR) && header_seen) begin
        addr_q   <= '0;
        byte_cnt <= '0;
        chk_q    <= '0;
      end
      if (state == S_COUNT && rx_valid) last_addr <= 7'(rx_byte - 8'd1);
      if (state == S_DATA && rx_valid) begin
        word_q   <= {word_q[23:0], rx_byte};
        chk_q    <= chk_q ^ rx_byte;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (word_done && !last_word) addr_q <= addr_q + 1'b1;
    end
  end

  assign CPU_RST  = (state != S_RUN);
  assign DONE     = (state == S_RUN);
  assign ERR      = (state == S_ERROR);
  assign CS       = (state == S_WRITE) || (state == S_VERIFY);
  assign WE       = (state == S_WRITE);
  assign BUS_OE   = (state == S_WRITE);
  assign ADDR     = (state == S_RUN) ? 7'd0 : addr_q;
  assign BUS_DATA = CS ? word_q : 32'd0;

endmodule
